read_pointer_handler_mc: RTL
============================

# read_pointer_handler_mc

Multi-channel, parametrised read-side pointer handler for the async FIFO bank on the receive clock domain. Each channel keeps an independent binary read counter and compares it with that channel's synchronised gray-coded write pointer. Per channel it produces:
- empty and almost-empty status;
- an exact fill level;
- a sticky underflow error;
- a registered gray-coded read pointer for the CDC synchroniser.

It also supports a per-channel flush that discards all pending entries in one cycle.

## Interface
- pointer_width, 3, address bits per channel FIFO; depth = 2^pointer_width.
- num_ch, 2, number of independent channels (≥1).
- aempty_thresh, 1, almost_empty asserts when level ≤ aempty_thresh (0..2^pointer_width).

Channel c occupies slice [c*W +: W] of every bus, where W is that bus's per-channel width.

- clk_rx  in  1  receive-domain clock; all state on rising edge.
- nrst_rx  in  1  asynchronous, active-low reset.
- pop  in  num_ch  per-channel read request.
- flush  in  num_ch  per-channel discard-all request.
- clr_underflow  in  num_ch  clears sticky underflow flag.
- synced_graycoded_write_pointer  in  num_ch*(pointer_width+1)  write pointers already synchronised into clk_rx, gray-coded.
- empty  out  num_ch  channel holds no entries (combinational).
- almost_empty  out  num_ch  level ≤ aempty_thresh (combinational).
- level  out  num_ch*(pointer_width+1)  entries available, 0..2^pointer_width (combinational).
- read_pointer  out  num_ch*pointer_width  RAM read address = read_counter[pointer_width-1:0].
- graycoded_read_pointer  out  num_ch*(pointer_width+1)  registered gray read pointer toward the write domain.
- underflow  out  num_ch  sticky: pop was issued while empty.

## Operation
Each channel has one (pointer_width+1)-bit read_counter. Counter arithmetic is modulo 2^(pointer_width+1).

Combinational outputs:
- wptr_bin = gray-to-binary(synced pointer).
- level = (wptr_bin − read_counter) mod 2^(pointer_width+1).
- empty = (bin-to-gray(read_counter) == synced pointer). This is equivalent to level == 0.
- almost_empty = (level ≤ aempty_thresh). It is therefore always asserted when empty.

Counter update per channel, in priority order:
- flush=1: read_counter ← wptr_bin. Any pop in the same cycle is ignored and never raises underflow.
- pop=1, empty=0: read_counter ← read_counter + 1. The counter wraps from 2^(pointer_width+1)−1 to 0.
- pop=1, empty=1: read_counter unchanged; underflow ← 1.
- otherwise: read_counter holds.

underflow rules:
- Stays 1 until a cycle with clr_underflow=1 and no new underflow event.
- A set in the same cycle as clr_underflow wins, so the flag stays 1.

graycoded_read_pointer ← bin-to-gray(read_counter) every cycle. It is a pure register: no combinational path from the counter reaches this output.

Channels share no state, and one channel's inputs never affect another's outputs.

Reset (asynchronous, while nrst_rx=0):
- read_counter, graycoded_read_pointer and underflow are 0 in all channels.
- read_pointer = 0.
- empty, almost_empty and level follow from the synced input. With the synced pointer at 0: empty=1, almost_empty=1, level=0.
- Asserting reset mid-operation clears state immediately, without a clock edge. Pending pop/flush are lost.

## Timing
- pop or flush sampled at edge k: read_counter and read_pointer update after edge k. empty, almost_empty and level reflect the new counter in the same cycle.
- graycoded_read_pointer reflects the counter value after edge k following edge k+1, i.e. one extra cycle of latency.
- Underflow event at edge k: underflow reads 1 after edge k.
- A change on the synced pointer affects empty, almost_empty and level combinationally in the same cycle.
- One pop per channel per cycle. Back-to-back pops sustain 1 entry per cycle while empty=0.

## Test plan
Parameters for all scenarios: pointer_width=3, num_ch=2, aempty_thresh=1.

1. **Reset**: hold nrst_rx=0 with synced=0 and no clock → all outputs 0 except empty=11 and almost_empty=11.
2. **Drain**: ch0 synced=0111 (bin 5), pop held for 6 cycles → level steps 5,4,3,2,1,0,0. almost_empty rises at level 1. empty rises after the 5th pop. read_pointer=5, graycoded_read_pointer=0111 one cycle later. The 6th pop sets underflow.
3. **Wrap**: ch0 read_counter=15, synced=0000 (bin 0), single pop → level goes from 1 to 0, read_counter=0, graycoded_read_pointer steps 1000→0000 one cycle later.
4. **Full level**: ch1 read_counter=0, synced=1100 (bin 8) → level=8, empty=0, almost_empty=0.
5. **Flush and underflow priority**:
   - ch0 read_counter=2, synced=0101 (bin 6), flush+pop same cycle → read_counter=6, level=0, empty=1, underflow stays 0.
   - Then pop+clr_underflow same cycle → underflow=1.
   - Then clr_underflow alone → underflow=0.
6. **Mid-operation reset and channel independence**:
   - Pop ch1 while ch0 idle → ch0 outputs unchanged.
   - Drop nrst_rx between clock edges → counters, gray outputs and underflow clear immediately.

Source files
------------

// File: rtl/read_pointer_handler_mc.sv
// Read-side pointer handler for a bank of async FIFOs, one independent
// channel per slice. Each channel keeps a binary read counter one bit wider
// than the RAM address, compares it against the synchronised gray write
// pointer and reports empty / almost-empty / exact level, a sticky
// underflow flag and a registered gray read pointer for the CDC path.
module read_pointer_handler_mc #(
  parameter int pointer_width = 3,
  parameter int num_ch        = 2,
  parameter int aempty_thresh = 1
) (
  input  logic                                clk_rx,
  input  logic                                nrst_rx,
  input  logic [num_ch-1:0]                   pop,
  input  logic [num_ch-1:0]                   flush,
  input  logic [num_ch-1:0]                   clr_underflow,
  input  logic [num_ch*(pointer_width+1)-1:0] synced_graycoded_write_pointer,
  output logic [num_ch-1:0]                   empty,
  output logic [num_ch-1:0]                   almost_empty,
  output logic [num_ch*(pointer_width+1)-1:0] level,
  output logic [num_ch*pointer_width-1:0]     read_pointer,
  output logic [num_ch*(pointer_width+1)-1:0] graycoded_read_pointer,
  output logic [num_ch-1:0]                   underflow
);

  localparam int pw1 = pointer_width + 1;

  // Threshold fits in pw1 bits because it never exceeds the FIFO depth.
  localparam logic [pointer_width:0] aempty_lim = pw1'(aempty_thresh);

  function automatic logic [pointer_width:0] bin2gray(input logic [pointer_width:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [pointer_width:0] gray2bin(input logic [pointer_width:0] g);
    logic [pointer_width:0] b;
    b[pointer_width] = g[pointer_width];
    for (int i = pointer_width - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  for (genvar c = 0; c < num_ch; c++) begin : g_ch
    logic [pointer_width:0] rd_cnt;
    logic [pointer_width:0] rd_gray_q;
    logic                   uf_q;
    logic [pointer_width:0] wptr_gray;
    logic [pointer_width:0] wptr_bin;
    logic [pointer_width:0] lvl;
    logic                   is_empty;
    logic                   uf_evt;

    assign wptr_gray = synced_graycoded_write_pointer[c*pw1 +: pw1];
    assign wptr_bin  = gray2bin(wptr_gray);
    assign lvl       = wptr_bin - rd_cnt;
    assign is_empty  = (bin2gray(rd_cnt) == wptr_gray);

    // A flush swallows any pop in the same cycle, so it can never underflow.
    assign uf_evt = pop[c] & ~flush[c] & is_empty;

    // Read counter: flush jumps to the write pointer, pop advances when data exists.
    always_ff @(posedge clk_rx or negedge nrst_rx) begin
      if (!nrst_rx) begin
        rd_cnt <= '0;
      end else if (flush[c]) begin
        rd_cnt <= wptr_bin;
      end else if (pop[c] && !is_empty) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end

    // Sticky underflow; a new event outranks the clear request.
    always_ff @(posedge clk_rx or negedge nrst_rx) begin
      if (!nrst_rx) begin
        uf_q <= 1'b0;
      end else if (uf_evt) begin
        uf_q <= 1'b1;
      end else if (clr_underflow[c]) begin
        uf_q <= 1'b0;
      end
    end

    // Gray pointer toward the write domain is launched straight from a flop.
    always_ff @(posedge clk_rx or negedge nrst_rx) begin
      if (!nrst_rx) begin
        rd_gray_q <= '0;
      end else begin
        rd_gray_q <= bin2gray(rd_cnt);
      end
    end

    assign empty[c]                                  = is_empty;
    assign almost_empty[c]                           = (lvl <= aempty_lim);
    assign level[c*pw1 +: pw1]                       = lvl;
    assign read_pointer[c*pointer_width +: pointer_width] = rd_cnt[pointer_width-1:0];
    assign graycoded_read_pointer[c*pw1 +: pw1]      = rd_gray_q;
    assign underflow[c]                              = uf_q;
  end

endmodule
